// File: rtl/traffic_light_monitor.sv
// Passive monitor for a four-phase traffic-light controller: it decodes the lamps back into a phase,
// locks onto the sequence, checks phase order and tick durations, and keeps sticky error flags.
module traffic_light_monitor #(
    parameter int DUR_G = 5,
    parameter int DUR_Y = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             ns_g,
    input  logic             ns_y,
    input  logic             ns_r,
    input  logic             ew_g,
    input  logic             ew_y,
    input  logic             ew_r,
    input  logic             clear,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             err_conflict,
    output logic             err_order,
    output logic             err_timing,
    output logic [CNT_W-1:0] err_count,
    output logic             cycle_done
);

    localparam int DUR_MAX = (DUR_G > DUR_Y) ? DUR_G : DUR_Y;
    localparam int TC_W    = $clog2(DUR_MAX + 2);

    typedef enum logic [2:0] {
        CODE_NS_G = 3'd0,
        CODE_NS_Y = 3'd1,
        CODE_EW_G = 3'd2,
        CODE_EW_Y = 3'd3,
        CODE_ILL  = 3'd4
    } code_t;

    typedef enum logic {S_SYNC, S_TRACK} state_t;

    state_t            r_state;
    code_t             r_prev;
    logic [1:0]        r_phase;
    logic [TC_W-1:0]   r_cnt;
    logic              r_tflag;
    logic              r_cycle_done;
    logic              r_err_conflict;
    logic              r_err_order;
    logic              r_err_timing;
    logic [CNT_W-1:0]  r_err_count;

    code_t             w_code;
    logic              w_succ;
    logic [TC_W-1:0]   w_dur;
    logic [TC_W-1:0]   w_cnt_inc;
    state_t            w_state_nx;
    logic [1:0]        w_phase_nx;
    logic [TC_W-1:0]   w_cnt_nx;
    logic              w_tflag_nx;
    logic              w_cycle_nx;
    logic              w_e_conf;
    logic              w_e_order;
    logic              w_e_tim;
    logic [1:0]        w_n_err;
    logic [CNT_W-1:0]  w_count_base;
    logic [CNT_W:0]    w_count_sum;
    logic [CNT_W-1:0]  w_count_nx;

    // Lamp vector is {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}; all six bits must match exactly.
    always_comb begin
        case ({ns_g, ns_y, ns_r, ew_g, ew_y, ew_r})
            6'b100_001: w_code = CODE_NS_G;
            6'b010_001: w_code = CODE_NS_Y;
            6'b001_100: w_code = CODE_EW_G;
            6'b001_010: w_code = CODE_EW_Y;
            default:    w_code = CODE_ILL;
        endcase
    end

    assign w_succ    = (r_prev != CODE_ILL) && (w_code != CODE_ILL) &&
                       (w_code[1:0] == 2'(r_prev[1:0] + 2'd1));
    assign w_dur     = r_phase[0] ? TC_W'(DUR_Y) : TC_W'(DUR_G);
    assign w_cnt_inc = (r_cnt == {TC_W{1'b1}}) ? r_cnt : r_cnt + TC_W'(1);

    // The first sample of a phase already carries that phase's first tick, so a new
    // visit starts its count at tick rather than 0.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nx = r_state;
        w_phase_nx = r_phase;
        w_cnt_nx   = r_cnt;
        w_tflag_nx = r_tflag;
        w_cycle_nx = 1'b0;
        w_e_conf   = 1'b0;
        w_e_order  = 1'b0;
        w_e_tim    = 1'b0;
        if (w_code == CODE_ILL) begin
            w_e_conf   = 1'b1;
            w_state_nx = S_SYNC;
        end else if (r_state == S_SYNC) begin
            if (w_succ) begin
                w_state_nx = S_TRACK;
                w_phase_nx = w_code[1:0];
                w_cnt_nx   = TC_W'(tick);
                w_tflag_nx = 1'b0;
            end
        end else if (w_code == r_prev) begin
            if (tick) begin
                if (r_cnt == w_dur && !r_tflag) begin
                    w_e_tim    = 1'b1;
                    w_tflag_nx = 1'b1;
                end
                w_cnt_nx = w_cnt_inc;
            end
        end else if (w_succ) begin
            w_e_tim    = (r_cnt != w_dur) && !r_tflag;
            w_phase_nx = w_code[1:0];
            w_cnt_nx   = TC_W'(tick);
            w_tflag_nx = 1'b0;
            w_cycle_nx = (r_phase == 2'd3);
        end else begin
            w_e_order  = 1'b1;
            w_state_nx = S_SYNC;
        end
    end

    // Clear only zeroes the base; errors of the same cycle are still added on top.
    assign w_n_err      = 2'(w_e_conf) + 2'(w_e_order) + 2'(w_e_tim);
    assign w_count_base = clear ? '0 : r_err_count;
    assign w_count_sum  = {1'b0, w_count_base} + (CNT_W + 1)'(w_n_err);
    assign w_count_nx   = w_count_sum[CNT_W] ? {CNT_W{1'b1}} : w_count_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_SYNC;
            r_prev         <= CODE_ILL;
            r_phase        <= 2'd0;
            r_cnt          <= '0;
            r_tflag        <= 1'b0;
            r_cycle_done   <= 1'b0;
            r_err_conflict <= 1'b0;
            r_err_order    <= 1'b0;
            r_err_timing   <= 1'b0;
            r_err_count    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state        <= w_state_nx;
            r_prev         <= w_code;
            r_phase        <= w_phase_nx;
            r_cnt          <= w_cnt_nx;
            r_tflag        <= w_tflag_nx;
            r_cycle_done   <= w_cycle_nx;
            r_err_conflict <= (r_err_conflict & ~clear) | w_e_conf;
            r_err_order    <= (r_err_order & ~clear) | w_e_order;
            r_err_timing   <= (r_err_timing & ~clear) | w_e_tim;
            r_err_count    <= w_count_nx;
        end
    end

    assign locked       = (r_state == S_TRACK);
    assign phase        = r_phase;
    assign err_conflict = r_err_conflict;
    assign err_order    = r_err_order;
    assign err_timing   = r_err_timing;
    assign err_count    = r_err_count;
    assign cycle_done   = r_cycle_done;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed lamp sequences push hand-derived expected
// outputs into a queue; a monitor pops one entry per sampled clock and compares.
module tb_traffic_light_monitor;

    localparam logic [5:0] P_NSG = 6'b100_001;
    localparam logic [5:0] P_NSY = 6'b010_001;
    localparam logic [5:0] P_EWG = 6'b001_100;
    localparam logic [5:0] P_EWY = 6'b001_010;
    localparam logic [5:0] P_BAD = 6'b100_101;

    typedef struct {
        string       name;
        logic [14:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, tick, clear;
    logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
    logic       locked, err_conflict, err_order, err_timing, cycle_done;
    logic [1:0] phase;
    logic [7:0] err_count;

    logic       e_locked, e_conf, e_order, e_tim;
    logic [1:0] e_phase;
    logic [7:0] e_cnt;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [14:0] w_obs;

    assign w_obs = {locked, phase, err_conflict, err_order, err_timing, err_count, cycle_done};

    always #5 clk = ~clk;

    traffic_light_monitor #(.DUR_G(5), .DUR_Y(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
        .clear(clear), .locked(locked), .phase(phase),
        .err_conflict(err_conflict), .err_order(err_order), .err_timing(err_timing),
        .err_count(err_count), .cycle_done(cycle_done)
    );

    // Field order: {locked, phase[1:0], err_conflict, err_order, err_timing, err_count[7:0], cycle_done}
    task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] pat, input logic tk, input logic clr,
                        input logic cd, input string nm);
        @(negedge clk);
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = pat;
        tick  = tk;
        clear = clr;
        exp_q.push_back('{nm, {e_locked, e_phase, e_conf, e_order, e_tim, e_cnt, cd}});
    endtask

    task automatic run_phase(input logic [5:0] pat, input logic [1:0] ph, input int n,
                             input logic cd_first, input string nm);
        e_locked = 1'b1;
        e_phase  = ph;
        for (int i = 0; i < n; i++) step(pat, 1'b1, 1'b0, (i == 0) ? cd_first : 1'b0, nm);
    endtask

    task automatic full_cycle(input string nm);
        run_phase(P_NSG, 2'd0, 5, 1'b1, nm);
        run_phase(P_NSY, 2'd1, 2, 1'b0, nm);
        run_phase(P_EWG, 2'd2, 5, 1'b0, nm);
        run_phase(P_EWY, 2'd3, 2, 1'b0, nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, w_obs, e.val);
            end
        end
    end

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0;
        tick  = 1'b1;
        clear = 1'b0;
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = P_NSG;
        {e_locked, e_conf, e_order, e_tim} = '0;
        e_phase = 2'd0;
        e_cnt   = 8'd0;

        // Reset state
        step(P_NSG, 1'b1, 1'b0, 1'b0, "reset_state");
        step(P_NSG, 1'b1, 1'b0, 1'b0, "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: clean run, lock on NS_G->NS_Y, cycle_done every 14 clocks
        for (int i = 0; i < 5; i++) step(P_NSG, 1'b1, 1'b0, 1'b0, "t1_sync");
        run_phase(P_NSY, 2'd1, 2, 1'b0, "t1_lock");
        run_phase(P_EWG, 2'd2, 5, 1'b0, "t1_ewg");
        run_phase(P_EWY, 2'd3, 2, 1'b0, "t1_ewy");
        repeat (3) full_cycle("t1_run");

        // 2: conflicting greens while locked, then relock
        run_phase(P_NSG, 2'd0, 2, 1'b1, "t2_pre");
        e_locked = 1'b0; e_conf = 1'b1; e_cnt = 8'd1;
        step(P_BAD, 1'b1, 1'b0, 1'b0, "t2_conflict");
        step(P_NSG, 1'b1, 1'b0, 1'b0, "t2_sync");
        step(P_NSG, 1'b1, 1'b0, 1'b0, "t2_sync");
        run_phase(P_NSY, 2'd1, 2, 1'b0, "t2_relock");
        run_phase(P_EWG, 2'd2, 5, 1'b0, "t2_ewg");
        run_phase(P_EWY, 2'd3, 2, 1'b0, "t2_ewy");

        // 3: NS_G left after only 4 ticks
        e_conf = 1'b0; e_cnt = 8'd0; e_phase = 2'd0;
        step(P_NSG, 1'b1, 1'b1, 1'b1, "t3_clear");
        for (int i = 0; i < 3; i++) step(P_NSG, 1'b1, 1'b0, 1'b0, "t3_nsg");
        e_tim = 1'b1; e_cnt = 8'd1; e_phase = 2'd1;
        step(P_NSY, 1'b1, 1'b0, 1'b0, "t3_early_exit");

        // 4: NS_Y overstays; flagged once per visit
        e_tim = 1'b0; e_cnt = 8'd0;
        step(P_NSY, 1'b1, 1'b1, 1'b0, "t4_clear");
        e_tim = 1'b1; e_cnt = 8'd1;
        step(P_NSY, 1'b1, 1'b0, 1'b0, "t4_overstay");
        step(P_NSY, 1'b1, 1'b0, 1'b0, "t4_no_repeat");
        run_phase(P_EWG, 2'd2, 5, 1'b0, "t4_ewg");
        run_phase(P_EWY, 2'd3, 2, 1'b0, "t4_ewy");

        // 5: out-of-order jump, clear, and error-beats-clear
        e_tim = 1'b0; e_cnt = 8'd0; e_phase = 2'd0;
        step(P_NSG, 1'b1, 1'b1, 1'b1, "t5_clear");
        for (int i = 0; i < 4; i++) step(P_NSG, 1'b1, 1'b0, 1'b0, "t5_nsg");
        e_locked = 1'b0; e_order = 1'b1; e_cnt = 8'd1;
        step(P_EWG, 1'b1, 1'b0, 1'b0, "t5_order");
        e_order = 1'b0; e_cnt = 8'd0;
        step(P_EWG, 1'b1, 1'b1, 1'b0, "t5_clear_flags");
        e_conf = 1'b1; e_cnt = 8'd1;
        step(P_BAD, 1'b1, 1'b1, 1'b0, "t5_error_wins_clear");
        e_conf = 1'b0; e_cnt = 8'd0;
        step(P_EWG, 1'b1, 1'b1, 1'b0, "t5_clear_again");
        step(P_EWG, 1'b1, 1'b0, 1'b0, "t5_sync");
        step(P_EWG, 1'b1, 1'b0, 1'b0, "t5_sync");
        run_phase(P_EWY, 2'd3, 2, 1'b0, "t5_relock");
        run_phase(P_NSG, 2'd0, 5, 1'b1, "t5_cycle");

        // 6: saturating error counter, then asynchronous reset mid-phase
        e_locked = 1'b0; e_conf = 1'b1;
        for (int i = 0; i < 260; i++) begin
            e_cnt = (i >= 254) ? 8'hFF : 8'(i + 1);
            step(P_BAD, 1'b1, 1'b0, 1'b0, "t6_saturate");
        end
        step(P_NSG, 1'b1, 1'b0, 1'b0, "t6_pre_reset");
        step(P_NSG, 1'b1, 1'b0, 1'b0, "t6_pre_reset");
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = P_EWG;
        #1;
        check("t6_async_reset", w_obs, 15'd0);
        {e_locked, e_conf, e_order, e_tim} = '0;
        e_phase = 2'd0;
        e_cnt   = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // 7: resync after reset ignores the partial phase; sparse ticks
        step(P_EWG, 1'b1, 1'b0, 1'b0, "t7_partial");
        step(P_EWG, 1'b1, 1'b0, 1'b0, "t7_partial");
        run_phase(P_EWY, 2'd3, 2, 1'b0, "t7_relock");
        e_phase = 2'd0;
        for (int i = 0; i < 10; i++) step(P_NSG, (i % 2 == 0), 1'b0, (i == 0), "t7_sparse_nsg");
        e_phase = 2'd1;
        for (int i = 0; i < 4; i++) step(P_NSY, (i % 2 == 0), 1'b0, 1'b0, "t7_sparse_nsy");
        e_phase = 2'd2;
        for (int i = 0; i < 6; i++) step(P_EWG, (i % 2 == 0), 1'b0, 1'b0, "t7_short_ewg");
        e_tim = 1'b1; e_cnt = 8'd1; e_phase = 2'd3;
        step(P_EWY, 1'b1, 1'b0, 1'b0, "t7_short_green");

        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 15'(exp_q.size()), 15'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker sitting on the six lamp outputs of the four-phase traffic-light controller (NS green → NS yellow → EW green → EW yellow), sharing its `clk` and `tick`. It decodes the lamp pattern back into a phase, locks onto the sequence, and counts ticks per phase. It flags conflicting lamps, out-of-order phases and wrong phase durations. Used in simulation and as an on-chip safety monitor; it never drives the lights.

## Interface
- `DUR_G`, default 5: ticks per green phase (NS and EW).
- `DUR_Y`, default 2: ticks per yellow phase (NS and EW).
- `CNT_W`, default 8: width of `err_count`.

- `clk` input 1: system clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick` input 1: same timebase pulse the controller consumes, one `clk` wide.
- `ns_g`, `ns_y`, `ns_r`, `ew_g`, `ew_y`, `ew_r` input 1 each: observed lamp outputs.
- `clear` input 1: synchronous clear of sticky error flags and `err_count`.
- `locked` output 1: monitor is synchronised to the phase sequence.
- `phase` output 2: decoded phase; 0=NS_G, 1=NS_Y, 2=EW_G, 3=EW_Y. Valid while `locked`.
- `err_conflict` output 1: sticky; illegal lamp pattern seen.
- `err_order` output 1: sticky; legal pattern entered out of sequence.
- `err_timing` output 1: sticky; phase ended early or overstayed.
- `err_count` output CNT_W: total error events, saturating at all-ones.
- `cycle_done` output 1: one-cycle pulse when EW_Y → NS_G completes a full locked cycle.

## Operation
- **Decode (combinational, per sample).** Exactly four one-hot legal codes: NS_G = {ns_g, ew_r}, NS_Y = {ns_y, ew_r}, EW_G = {ew_g, ns_r}, EW_Y = {ew_y, ns_r}. All six bits are compared; the four unlisted lamps must be 0. Any other pattern is ILLEGAL, including all-off and all-red.
- **FSM states:** SYNC, TRACK.
  - SYNC: waits for a sample whose legal code is the correct successor of the previous sample's legal code. On it: TRACK, `phase` ← new code, tick count ← 0. Timing and order are not checked in SYNC.
  - TRACK, same code as previous sample: if `tick`, increment the tick count. If `tick` arrives with count already equal to DUR(phase), raise `err_timing` once per phase visit.
  - TRACK, code changes to the correct successor: if count ≠ DUR(phase), raise `err_timing`. Then `phase` ← successor and count ← 0.
  - TRACK, code changes to any other legal code: raise `err_order`, go to SYNC.
- **Any state, ILLEGAL sample:** raise `err_conflict`, go to SYNC.
- DUR(phase) is DUR_G for phases 0 and 2, DUR_Y for phases 1 and 3.
- Tick count is counted including the tick on which the controller transitions, so a correct phase shows exactly DUR ticks.
- The tick counter width covers max(DUR_G, DUR_Y)+1 and saturates; it never wraps.
- **Error flags:**
  - Each raised error sets its sticky flag and adds 1 to `err_count`.
  - Simultaneous errors in one cycle add the number of distinct errors, saturating.
  - `clear` zeroes the flags and `err_count`. An error in the same cycle as `clear` wins: its flag ends at 1 and the count ends at the number of errors in that cycle.
- `cycle_done` pulses on the TRACK transition EW_Y → NS_G, whether or not it carried `err_timing`.

## Timing
- Inputs are sampled at each rising `clk`. A "previous sample" register holds the last decoded code; it resets to ILLEGAL, and an ILLEGAL previous code never matches any successor.
- All outputs are registered. Flags, `phase`, `locked` and `cycle_done` update on the same edge that samples the offending or transitioning pattern. This gives 1-cycle latency from the lamp change to the output.
- Reset values: `locked`=0, `phase`=0, all `err_*`=0, `err_count`=0, `cycle_done`=0, FSM in SYNC, tick count 0.
- Asserting `rst_n` low mid-operation clears everything immediately. After release the monitor resynchronises through SYNC and never flags the partial first phase.
- `locked` = (state == TRACK).

## Test plan
1. DUR_G=5, DUR_Y=2, `tick` every cycle, controller running correctly from reset → `locked`=1 after the first NS_G→NS_Y change. No errors over 3 cycles, and `cycle_done` pulses every 14 clk.
2. Force `ns_g` and `ew_g` both high for one cycle while locked → `err_conflict`=1 next edge, `locked`=0, `err_count`=1. Relock after the next correct transition.
3. Controller leaves NS_G after 4 ticks → `err_timing`=1, `err_count`=1, `phase`=1, `locked` stays 1.
4. Hold NS_Y for a 3rd tick → `err_timing` set on that tick only (count 1), not repeated on a 4th tick.
5. Jump NS_G→EW_G while locked → `err_order`=1, `locked`=0; `clear` pulse next cycle → all flags 0, `err_count`=0.
6. Inject 260 conflicts with CNT_W=8 → `err_count` holds 255. Pull `rst_n` low mid-phase → all outputs 0 asynchronously.
